multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Sequencing FSM for the multi-cycle RV32I datapath variant: one shared instruction/data memory port, one ALU, with IR/PC/ALUOut/MDR holding registers between cycles.
- Decodes the held IR and drives per-cycle datapath selects. Keeps the single-cycle ALUControl, ImmSrc and MemWrite encodings, so the ALU, extender and store shifters are reused unchanged.
- Stalls on a memory ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into PC via pc_init during reset.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- instr  in  32  current IR contents
- equal  in  1  ALU equality flag (RD1==RD2)
- less_than  in  1  ALU compare result (signed or unsigned, per ALUControl)
- mem_ready  in  1  memory completes the pending access this cycle
- mem_req  out  1  memory access request
- adr_src  out  1  0=PC, 1=ALUOut as memory address
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  load PC (unconditional)
- pc_init  out  1  force PC<=RESET_PC
- src_a_sel  out  2  00=RD1, 01=PC, 10=oldPC
- src_b_sel  out  2  00=RD2, 01=imm, 10=constant 4
- imm_src  out  3  000 I, 001 B, 010 S, 011 J, 100 U
- alu_control  out  4  codebase ALU encoding
- result_sel  out  2  00=ALUOut, 01=MDR, 10=ALU result direct
- reg_write  out  1  register-file write enable
- mem_write  out  2  00 byte, 01 half, 10 word, 11 no write
- shamt_control  out  2  00 zero, 01 RD2[4:0], 10 imm[4:0]
- shifter_control  out  2  00 SLL, 01 SRL, 10 SRA
- illegal_instr  out  1  one-cycle pulse on unknown opcode
- state_o  out  4  current state, for debug/verification

Behaviour:
- Reset (reset_n=0 at a clk edge): state<=FETCH.
  - During reset cycles pc_init=1. All other enables are 0 and mem_write=11.
  - Reset mid-access abandons the access; mem_req drops the same cycle reset is sampled.
- Outputs are Moore (decoded from state + instr); no output depends on mem_ready combinationally, except ir_write/pc_write as stated below. Default for all outputs: 0, mem_write=11.
- FETCH:
  - mem_req=1, adr_src=0, src_a_sel=01, src_b_sel=10, alu_control=1011.
  - Holds while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1 (PC<=PC+4, old PC latched), next DECODE.
- DECODE:
  - src_a_sel=10, src_b_sel=01, imm_src=001, alu_control=1011 (branch target into ALUOut).
  - Dispatch on instr[6:0]:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 or 0010111 -> EXEC_U
    - other -> FETCH, with illegal_instr=1
- MEMADR: src_a_sel=00, src_b_sel=01, imm_src=000 (load) / 010 (store), alu_control=1011. Next MEMRD (load) or MEMWR (store).
- MEMRD: mem_req=1, adr_src=1. Hold until mem_ready, then MEMWB.
- MEMWB: result_sel=01, reg_write=1. Next FETCH.
- MEMWR: mem_req=1, adr_src=1, mem_write={instr[13],instr[12]}. Hold until mem_ready, then FETCH. mem_write is driven only while in MEMWR.
- EXEC_R / EXEC_I:
  - funct3 map: 111->0000, 100->0101, 110->0001, 010->0100, 011->0110.
  - funct3 000:
    - R-type: 1011, or 1100 when instr[30]=1.
    - I-type: 1011 always.
  - Shifts (funct3 001/101): alu_control=1110.
    - shifter_control: 00 for 001; for 101, instr[30] ? 10 : 01.
    - shamt_control: 01 for R-type, 10 for I-type.
  - Next ALUWB.
- ALUWB: result_sel=00, reg_write=1. Next FETCH.
- BRANCH:
  - src_a_sel=00, src_b_sel=00, result_sel=00.
  - alu_control by instr[14:13]: 00->1001, 10->1000, 11->0111.
  - taken = (instr[14] ? less_than : equal) XOR instr[12].
  - pc_write=taken (PC<=ALUOut). Next FETCH.
  - instr[14:13]=01 is illegal: illegal_instr=1, no pc_write.
- JAL:
  - Write oldPC+4: src_a_sel=10, src_b_sel=10, alu_control=1011, result_sel=10, reg_write=1.
  - Target: imm_src=011 was precomputed in DECODE; DECODE uses imm_src=011 when opcode=1101111. result_sel=00 path feeds PC, pc_write=1.
  - Next FETCH.
- JALR: two cycles.
  - JALR: src_a_sel=00, src_b_sel=01, imm_src=000, alu_control=1011; ALUOut latches the target. Next JALR_LINK.
  - JALR_LINK: link write as JAL, plus PC<=ALUOut & ~1. Next FETCH.
- EXEC_U:
  - imm_src=100, src_b_sel=01.
  - LUI: alu_control=1101. AUIPC: src_a_sel=10, alu_control=1011.
  - Next ALUWB.
- CPI:
  - ALU ops 4, branch 3, JAL 3, JALR 4, load 5, store 4.
  - Plus one cycle per mem_ready=0 wait cycle.

Decomposition:
- Shared package riscv_ctrl_pkg: opcode constants, ALUControl codes, ImmSrc codes, mem_write size codes, state enum.
- One natural sub-module, alu_decoder (combinational: opcode/funct3/instr[30] -> alu_control, shifter_control, shamt_control), also reusable by the single-cycle controller.

Test Plan:
- Reset: reset_n=0 for 2 cycles -> state_o=FETCH, pc_init=1, reg_write=0, mem_write=11. Release -> mem_req=1, adr_src=0.
- add x3,x1,x2 (32'h002081B3), mem_ready=1 -> FETCH,DECODE,EXEC_R,ALUWB; alu_control=1011; reg_write=1 only in ALUWB. Same with sub (32'h402081B3) -> 1100.
- lw x5,8(x1) with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_req=1, adr_src=1, then MEMWB with result_sel=01.
- sh x2,4(x1) (32'h00209223) -> MEMWR with mem_write=01, reg_write=0 throughout.
- bne x1,x2 with equal=1 -> pc_write=0. With equal=0 -> pc_write=1 in BRANCH. bgeu, less_than=0 -> alu_control=0111, taken.
- Opcode 7'b1111111 -> illegal_instr single pulse in DECODE, next FETCH. reset_n=0 during MEMWR -> next state FETCH, no mem_write.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I controllers: opcodes, ALU/immediate/store codes,
// datapath select codes and the multi-cycle sequencer state enum.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_CMPU  = 4'b0111;
    localparam logic [3:0] ALU_CMPS  = 4'b1000;
    localparam logic [3:0] ALU_CMPEQ = 4'b1001;
    localparam logic [3:0] ALU_ADD   = 4'b1011;
    localparam logic [3:0] ALU_SUB   = 4'b1100;
    localparam logic [3:0] ALU_LUI   = 4'b1101;
    localparam logic [3:0] ALU_SHIFT = 4'b1110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_B = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [1:0] MEM_NONE = 2'b11;

    localparam logic [1:0] SRC_A_RD1   = 2'b00;
    localparam logic [1:0] SRC_A_PC    = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;
    localparam logic [1:0] SRC_B_RD2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RESULT_ALUOUT = 2'b00;
    localparam logic [1:0] RESULT_MDR    = 2'b01;
    localparam logic [1:0] RESULT_ALU    = 2'b10;

    localparam logic [1:0] SHAMT_ZERO = 2'b00;
    localparam logic [1:0] SHAMT_RD2  = 2'b01;
    localparam logic [1:0] SHAMT_IMM  = 2'b10;
    localparam logic [1:0] SHIFT_SLL  = 2'b00;
    localparam logic [1:0] SHIFT_SRL  = 2'b01;
    localparam logic [1:0] SHIFT_SRA  = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEMADR    = 4'd2,
        ST_MEMRD     = 4'd3,
        ST_MEMWB     = 4'd4,
        ST_MEMWR     = 4'd5,
        ST_EXEC_R    = 4'd6,
        ST_EXEC_I    = 4'd7,
        ST_ALUWB     = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JAL       = 4'd10,
        ST_JALR      = 4'd11,
        ST_JALR_LINK = 4'd12,
        ST_EXEC_U    = 4'd13
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decode shared with the single-cycle controller:
// opcode/funct3/instr[30] -> ALU operation, shifter mode and shift-amount source.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       instr30,
    output logic [3:0] alu_control,
    output logic [1:0] shifter_control,
    output logic [1:0] shamt_control
);

    always_comb begin
        alu_control     = ALU_AND;
        shifter_control = SHIFT_SLL;
        shamt_control   = SHAMT_ZERO;
        if (opcode == OP_BRANCH) begin
            // funct3[2:1] selects the comparison; funct3[0] only inverts the outcome
            case (funct3[2:1])
                2'b00:   alu_control = ALU_CMPEQ;
                2'b10:   alu_control = ALU_CMPS;
                2'b11:   alu_control = ALU_CMPU;
                default: alu_control = ALU_AND;
            endcase
        end else begin
            case (funct3)
                3'b000:  alu_control = (opcode == OP_R && instr30) ? ALU_SUB : ALU_ADD;
                3'b111:  alu_control = ALU_AND;
                3'b110:  alu_control = ALU_OR;
                3'b100:  alu_control = ALU_XOR;
                3'b010:  alu_control = ALU_SLT;
                3'b011:  alu_control = ALU_SLTU;
                3'b001: begin
                    alu_control     = ALU_SHIFT;
                    shifter_control = SHIFT_SLL;
                    shamt_control   = (opcode == OP_R) ? SHAMT_RD2 : SHAMT_IMM;
                end
                default: begin
                    alu_control     = ALU_SHIFT;
                    shifter_control = instr30 ? SHIFT_SRA : SHIFT_SRL;
                    shamt_control   = (opcode == OP_R) ? SHAMT_RD2 : SHAMT_IMM;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I datapath: decodes the held IR and drives
// per-cycle datapath selects, stalling on the shared memory port's ready handshake.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        equal,
    input  logic        less_than,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_init,
    output logic [1:0]  src_a_sel,
    output logic [1:0]  src_b_sel,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_control,
    output logic [1:0]  result_sel,
    output logic        reg_write,
    output logic [1:0]  mem_write,
    output logic [1:0]  shamt_control,
    output logic [1:0]  shifter_control,
    output logic        illegal_instr,
    output logic [3:0]  state_o
);

    // Memory handshake: mem_req is held high for the whole access; the access
    // completes in the cycle mem_ready is seen high while mem_req is high.

    state_t     state, state_next;
    logic [6:0] opcode;
    logic [3:0] dec_alu_control;
    logic [1:0] dec_shifter_control;
    logic [1:0] dec_shamt_control;
    logic       taken;
    logic       unused_bits;

    assign opcode  = instr[6:0];
    assign state_o = state;
    // RESET_PC is applied by the datapath's PC register when pc_init is high
    assign unused_bits = ^{RESET_PC, instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .opcode          (opcode),
        .funct3          (instr[14:12]),
        .instr30         (instr[30]),
        .alu_control     (dec_alu_control),
        .shifter_control (dec_shifter_control),
        .shamt_control   (dec_shamt_control)
    );

    assign taken = (instr[14] ? less_than : equal) ^ instr[12];

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_FETCH;
        else          state <= state_next;
    end

    always_comb begin
        state_next      = state;
        mem_req         = 1'b0;
        adr_src         = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        pc_init         = 1'b0;
        src_a_sel       = SRC_A_RD1;
        src_b_sel       = SRC_B_RD2;
        imm_src         = IMM_I;
        alu_control     = ALU_AND;
        result_sel      = RESULT_ALUOUT;
        reg_write       = 1'b0;
        mem_write       = MEM_NONE;
        shamt_control   = SHAMT_ZERO;
        shifter_control = SHIFT_SLL;
        illegal_instr   = 1'b0;

        case (state)
            ST_FETCH: begin
                mem_req     = 1'b1;
                src_a_sel   = SRC_A_PC;
                src_b_sel   = SRC_B_FOUR;
                alu_control = ALU_ADD;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // ALUOut captures the branch or JAL target for use in a later state
                src_a_sel   = SRC_A_OLDPC;
                src_b_sel   = SRC_B_IMM;
                imm_src     = (opcode == OP_JAL) ? IMM_J : IMM_B;
                alu_control = ALU_ADD;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = ST_MEMADR;
                    OP_R:              state_next = ST_EXEC_R;
                    OP_I:              state_next = ST_EXEC_I;
                    OP_BRANCH:         state_next = ST_BRANCH;
                    OP_JAL:            state_next = ST_JAL;
                    OP_JALR:           state_next = ST_JALR;
                    OP_LUI, OP_AUIPC:  state_next = ST_EXEC_U;
                    default: begin
                        illegal_instr = 1'b1;
                        state_next    = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                src_b_sel   = SRC_B_IMM;
                imm_src     = (opcode == OP_STORE) ? IMM_S : IMM_I;
                alu_control = ALU_ADD;
                state_next  = (opcode == OP_STORE) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_next = ST_MEMWB;
            end
            ST_MEMWB: begin
                result_sel = RESULT_MDR;
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEMWR: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = instr[13:12];
                if (mem_ready) state_next = ST_FETCH;
            end
            ST_EXEC_R, ST_EXEC_I: begin
                src_b_sel       = (state == ST_EXEC_I) ? SRC_B_IMM : SRC_B_RD2;
                alu_control     = dec_alu_control;
                shifter_control = dec_shifter_control;
                shamt_control   = dec_shamt_control;
                state_next      = ST_ALUWB;
            end
            ST_ALUWB: begin
                result_sel = RESULT_ALUOUT;
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_control = dec_alu_control;
                if (instr[14:13] == 2'b01) illegal_instr = 1'b1;
                else                       pc_write      = taken;
                state_next = ST_FETCH;
            end
            ST_JAL, ST_JALR_LINK: begin
                // Link value oldPC+4 goes straight to the register file; PC takes ALUOut
                src_a_sel   = SRC_A_OLDPC;
                src_b_sel   = SRC_B_FOUR;
                alu_control = ALU_ADD;
                result_sel  = RESULT_ALU;
                reg_write   = 1'b1;
                pc_write    = 1'b1;
                state_next  = ST_FETCH;
            end
            ST_JALR: begin
                src_b_sel   = SRC_B_IMM;
                imm_src     = IMM_I;
                alu_control = ALU_ADD;
                state_next  = ST_JALR_LINK;
            end
            ST_EXEC_U: begin
                imm_src   = IMM_U;
                src_b_sel = SRC_B_IMM;
                if (opcode == OP_AUIPC) begin
                    src_a_sel   = SRC_A_OLDPC;
                    alu_control = ALU_ADD;
                end else begin
                    alu_control = ALU_LUI;
                end
                state_next = ST_ALUWB;
            end
            default: state_next = ST_FETCH;
        endcase

        // Reset abandons any pending access in the very cycle it is sampled
        if (!reset_n) begin
            state_next      = ST_FETCH;
            mem_req         = 1'b0;
            adr_src         = 1'b0;
            ir_write        = 1'b0;
            pc_write        = 1'b0;
            pc_init         = 1'b1;
            src_a_sel       = SRC_A_RD1;
            src_b_sel       = SRC_B_RD2;
            imm_src         = IMM_I;
            alu_control     = ALU_AND;
            result_sel      = RESULT_ALUOUT;
            reg_write       = 1'b0;
            mem_write       = MEM_NONE;
            shamt_control   = SHAMT_ZERO;
            shifter_control = SHIFT_SLL;
            illegal_instr   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level reference model expands each
// instruction into its expected per-cycle control vectors, compared cycle by cycle.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       pc_init;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] imm;
        logic [3:0] alu;
        logic [1:0] res;
        logic       reg_write;
        logic [1:0] mem_write;
        logic [1:0] shamt;
        logic [1:0] shifter;
        logic       illegal;
    } vec_t;

    localparam int W = $bits(vec_t);

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        equal = 1'b0;
    logic        less_than = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, adr_src, ir_write, pc_write, pc_init, reg_write, illegal_instr;
    logic [1:0]  src_a_sel, src_b_sel, result_sel, mem_write, shamt_control, shifter_control;
    logic [2:0]  imm_src;
    logic [3:0]  alu_control, state_o;

    logic [W-1:0] exp_q[$];
    logic         rdy_q[$];
    int vectors = 0;
    int miscompares = 0;

    multicycle_controller #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset_n(reset_n), .instr(instr), .equal(equal), .less_than(less_than),
        .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .pc_init(pc_init), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
        .imm_src(imm_src), .alu_control(alu_control), .result_sel(result_sel),
        .reg_write(reg_write), .mem_write(mem_write), .shamt_control(shamt_control),
        .shifter_control(shifter_control), .illegal_instr(illegal_instr), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t idle(input logic [3:0] s);
        vec_t v;
        v = '0;
        v.state = s;
        v.mem_write = 2'b11;
        return v;
    endfunction

    function automatic vec_t observed();
        vec_t v;
        v.state = state_o;       v.mem_req = mem_req;     v.adr_src = adr_src;
        v.ir_write = ir_write;   v.pc_write = pc_write;   v.pc_init = pc_init;
        v.src_a = src_a_sel;     v.src_b = src_b_sel;     v.imm = imm_src;
        v.alu = alu_control;     v.res = result_sel;      v.reg_write = reg_write;
        v.mem_write = mem_write; v.shamt = shamt_control; v.shifter = shifter_control;
        v.illegal = illegal_instr;
        return v;
    endfunction

    // ALU operation implied by an R/I-type instruction's function fields
    function automatic logic [3:0] alu_ref(input bit is_r, input logic [2:0] f3, input logic b30);
        case (f3)
            3'b000:  return (is_r && b30) ? 4'b1100 : 4'b1011;
            3'b111:  return 4'b0000;
            3'b110:  return 4'b0001;
            3'b100:  return 4'b0101;
            3'b010:  return 4'b0100;
            3'b011:  return 4'b0110;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic bit branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'b000:  return eq;    // beq
            3'b001:  return !eq;   // bne
            3'b100:  return lt;    // blt
            3'b101:  return !lt;   // bge
            3'b110:  return lt;    // bltu
            default: return !lt;   // bgeu
        endcase
    endfunction

    function automatic void push(input vec_t v, input logic rdy);
        exp_q.push_back(v);
        rdy_q.push_back(rdy);
    endfunction

    function automatic logic any_rdy();
        return logic'($urandom_range(0, 1));
    endfunction

    // Expands one instruction into its expected cycle-by-cycle control vectors
    task automatic model_instr(input logic [31:0] ins, input int fetch_waits,
                               input int mem_waits, input logic eq, input logic lt);
        vec_t v, fv;
        logic [6:0] opc;
        logic [2:0] f3;
        bit is_r;
        opc = ins[6:0];
        f3  = ins[14:12];
        fv = idle(ST_FETCH);
        fv.mem_req = 1; fv.src_a = 2'b01; fv.src_b = 2'b10; fv.alu = 4'b1011;
        for (int i = 0; i < fetch_waits; i++) push(fv, 1'b0);
        fv.ir_write = 1; fv.pc_write = 1;
        push(fv, 1'b1);

        v = idle(ST_DECODE);
        v.src_a = 2'b10; v.src_b = 2'b01; v.alu = 4'b1011;
        v.imm = (opc == 7'b1101111) ? 3'b011 : 3'b001;
        if (!(opc inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR,
                          OP_LUI, OP_AUIPC})) begin
            v.illegal = 1;
            push(v, any_rdy());
            return;
        end
        push(v, any_rdy());

        case (opc)
            OP_LOAD, OP_STORE: begin
                v = idle(ST_MEMADR);
                v.src_b = 2'b01; v.alu = 4'b1011;
                v.imm = (opc == OP_STORE) ? 3'b010 : 3'b000;
                push(v, any_rdy());
                v = idle((opc == OP_STORE) ? ST_MEMWR : ST_MEMRD);
                v.mem_req = 1; v.adr_src = 1;
                if (opc == OP_STORE) v.mem_write = ins[13:12];
                for (int i = 0; i < mem_waits; i++) push(v, 1'b0);
                push(v, 1'b1);
                if (opc == OP_LOAD) begin
                    v = idle(ST_MEMWB);
                    v.res = 2'b01; v.reg_write = 1;
                    push(v, any_rdy());
                end
            end
            OP_R, OP_I: begin
                is_r = (opc == OP_R);
                v = idle(is_r ? ST_EXEC_R : ST_EXEC_I);
                v.src_b = is_r ? 2'b00 : 2'b01;
                v.alu = alu_ref(is_r, f3, ins[30]);
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    v.shamt = is_r ? 2'b01 : 2'b10;
                    v.shifter = (f3 == 3'b001) ? 2'b00 : (ins[30] ? 2'b10 : 2'b01);
                end
                push(v, any_rdy());
                v = idle(ST_ALUWB);
                v.reg_write = 1;
                push(v, any_rdy());
            end
            OP_BRANCH: begin
                v = idle(ST_BRANCH);
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    v.illegal = 1;
                end else begin
                    v.alu = (f3[2] == 0) ? 4'b1001 : (f3[1] ? 4'b0111 : 4'b1000);
                    v.pc_write = branch_taken(f3, eq, lt);
                end
                push(v, any_rdy());
            end
            OP_JAL, OP_JALR: begin
                if (opc == OP_JALR) begin
                    v = idle(ST_JALR);
                    v.src_b = 2'b01; v.alu = 4'b1011;
                    push(v, any_rdy());
                end
                v = idle((opc == OP_JALR) ? ST_JALR_LINK : ST_JAL);
                v.src_a = 2'b10; v.src_b = 2'b10; v.alu = 4'b1011;
                v.res = 2'b10; v.reg_write = 1; v.pc_write = 1;
                push(v, any_rdy());
            end
            default: begin
                v = idle(ST_EXEC_U);
                v.imm = 3'b100; v.src_b = 2'b01;
                if (opc == OP_AUIPC) begin
                    v.src_a = 2'b10; v.alu = 4'b1011;
                end else begin
                    v.alu = 4'b1101;
                end
                push(v, any_rdy());
                v = idle(ST_ALUWB);
                v.reg_write = 1;
                push(v, any_rdy());
            end
        endcase
    endtask

    // Applies queued mem_ready values and checks each cycle's outputs; entered #1 after posedge
    task automatic drain(input string tag);
        vec_t e, o;
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            o = observed();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %h required %h (state got %0d required %0d)",
                         tag, cyc, o, e, o.state, e.state);
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input string tag, input logic [31:0] ins, input int fw,
                             input int mw, input logic eq, input logic lt);
        instr = ins; equal = eq; less_than = lt;
        model_instr(ins, fw, mw, eq, lt);
        drain(tag);
    endtask

    task automatic check_bit(input string tag, input logic got, input logic req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %b required %b", tag, got, req);
        end
    endtask

    task automatic check_bits(input string tag, input logic [3:0] got, input logic [3:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", tag, got, req);
        end
    endtask

    task automatic test_reset();
        reset_n = 0; mem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_bits("reset_state", state_o, ST_FETCH);
            check_bit("reset_pc_init", pc_init, 1'b1);
            check_bit("reset_reg_write", reg_write, 1'b0);
            check_bits("reset_mem_write", {2'b00, mem_write}, 4'b0011);
            check_bit("reset_mem_req", mem_req, 1'b0);
        end
        @(posedge clk); #1;
        reset_n = 1;
        @(negedge clk);
        check_bit("release_mem_req", mem_req, 1'b1);
        check_bit("release_adr_src", adr_src, 1'b0);
        check_bit("release_pc_init", pc_init, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        run_instr("add", 32'h002081B3, 0, 0, 0, 0);
        run_instr("sub", 32'h402081B3, 1, 0, 0, 0);
        run_instr("addi_b30", 32'h40008093, 0, 0, 0, 0);
        run_instr("srai", 32'h4010D093, 0, 0, 0, 0);
        run_instr("sra", 32'h4020D1B3, 0, 0, 0, 0);
        run_instr("slli", 32'h00109093, 0, 0, 0, 0);
        run_instr("lui", 32'h123450B7, 0, 0, 0, 0);
        run_instr("auipc", 32'h00001097, 0, 0, 0, 0);
    endtask

    task automatic test_memory();
        run_instr("lw_wait", 32'h0080A283, 0, 3, 0, 0);
        run_instr("sh", 32'h00209223, 0, 0, 0, 0);
        run_instr("sb_wait", 32'h00208223, 2, 2, 0, 0);
        run_instr("sw", 32'h0020A223, 0, 1, 0, 0);
    endtask

    task automatic test_branch_jump();
        run_instr("bne_eq", 32'h00209063, 0, 0, 1, 0);
        run_instr("bne_ne", 32'h00209063, 0, 0, 0, 0);
        run_instr("bgeu_ge", 32'h0020F063, 0, 0, 0, 0);
        run_instr("blt_lt", 32'h0020C063, 0, 0, 1, 1);
        run_instr("beq_ne", 32'h00208063, 0, 0, 0, 1);
        run_instr("br_illegal", 32'h0020A063, 0, 0, 1, 1);
        run_instr("jal", 32'h008000EF, 0, 0, 0, 0);
        run_instr("jalr", 32'h004080E7, 0, 0, 0, 0);
    endtask

    task automatic test_illegal();
        run_instr("illegal_7f", 32'h0000007F, 0, 0, 0, 0);
        run_instr("after_illegal", 32'h002081B3, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_store();
        instr = 32'h0020A223; equal = 0; less_than = 0;
        model_instr(instr, 0, 1, 0, 0);
        void'(exp_q.pop_back());
        void'(rdy_q.pop_back());
        drain("store_before_reset");
        reset_n = 0; mem_ready = 1;
        @(negedge clk);
        check_bit("midreset_mem_req", mem_req, 1'b0);
        check_bits("midreset_mem_write", {2'b00, mem_write}, 4'b0011);
        check_bit("midreset_pc_init", pc_init, 1'b1);
        @(posedge clk); #1;
        reset_n = 1; mem_ready = 0;
        @(negedge clk);
        check_bits("midreset_next_state", state_o, ST_FETCH);
        check_bits("midreset_after_mem_write", {2'b00, mem_write}, 4'b0011);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [12];
        logic [31:0] ins;
        ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI,
                OP_AUIPC, 7'b1111111, 7'b0000000, 7'b1110011};
        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 11)];
            run_instr("random", ins, $urandom_range(0, 2), $urandom_range(0, 3),
                      logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_memory();
        test_branch_jump();
        test_illegal();
        test_reset_mid_store();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
